key_input_unit: RTL and testbench
=================================

Name: key_input_unit

Overview:
Front-end for the four player push-buttons. It feeds the game control stage directly.
- Synchronises and debounces four raw active-low buttons.
- Emits one-cycle press pulses key1_press..key4_press, consumed by the game control stage to leave START.
- Keeps a registered movement direction for the snake movement stage, with immediate-reversal rejection.
- Re-centres the direction when the control stage asserts restart.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles a synchronised key level must stay unchanged before it is accepted (20 ms at 50 MHz); legal range 2..2^24-1.
CNT_W, 24, width of each per-key debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
CLK_50M  in  1  system clock, 50 MHz
RSTn  in  1  asynchronous active-low reset
key1_n  in  1  raw button UP, active-low, asynchronous to CLK_50M
key2_n  in  1  raw button DOWN, active-low
key3_n  in  1  raw button LEFT, active-low
key4_n  in  1  raw button RIGHT, active-low
restart  in  1  level from game control; high forces direction to RIGHT
key1_press  out  1  one-cycle pulse on accepted press of key1
key2_press  out  1  one-cycle pulse on accepted press of key2
key3_press  out  1  one-cycle pulse on accepted press of key3
key4_press  out  1  one-cycle pulse on accepted press of key4
key_level  out  4  debounced pressed levels, 1 = held; bit0 = key1
direction  out  2  00 UP, 01 DOWN, 10 LEFT, 11 RIGHT

Behaviour:
Clock and reset
- One clock domain: CLK_50M.
- RSTn is asynchronous assert, active-low. Deassertion is used synchronously as delivered by the board reset logic.

Reset values
- Synchroniser flops: 1 (released).
- Debounce counters: 0.
- key_level: 4'b0000.
- All keyN_press: 0.
- direction: 2'b11 (RIGHT).

Synchroniser
- Each key_n passes through a 2-flop synchroniser.
- The synchronised pressed level is s_k = ~sync2.

Debounce, per key and independent
- If s_k equals key_level[k], the counter clears to 0.
- Otherwise the counter increments each cycle.
- When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, key_level[k] takes s_k on that edge and the counter clears.
- Any glitch back to the current level restarts the count from 0.

Press pulse and latency
- keyN_press is high for exactly one cycle, on the cycle after key_level[k] rises 0->1.
- Release (1->0) produces no pulse.
- Latency from a clean raw falling edge to the keyN_press high cycle = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Holding a key produces exactly one pulse. Another pulse requires a debounced release followed by a debounced press.

Direction register
- Updated on the same cycle the press pulses are high (registered, visible the next cycle).
- When several pulses are high in one cycle, priority is key1 > key2 > key3 > key4. Only the winner is considered.
- Reversal rejection: a request for the direct opposite of the current direction is ignored and the direction is unchanged. The pairs are UP/DOWN and LEFT/RIGHT.
- If the winner is rejected, lower-priority simultaneous requests are NOT considered.
- A request for the same direction leaves it unchanged.

Restart
- While restart = 1, direction <= RIGHT every cycle and overrides any press.
- Press pulses and debounce continue unaffected, because the control stage ignores them in RESTART.

Reset mid-operation
- Asserting RSTn low mid-debounce discards the partial count.
- A key held through reset release is re-debounced and generates one press pulse after the full latency.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=8.
1. Clean press: key1_n held low from cycle 10 -> key_level[0]=1 from cycle 20, key1_press high only in cycle 21; direction 11->00 visible cycle 22.
2. Bounce: key3_n toggles low/high every 3 cycles for 30 cycles, then stays low -> no key3_press during bouncing; exactly one pulse 11 cycles after the final stable low; direction LEFT is rejected (RIGHT opposite), stays 11.
3. Reversal chain: starting from reset, press key1 (UP) then key2 (DOWN) then key3 (LEFT) -> direction 00, stays 00, then 10.
4. Simultaneous: key2_n and key3_n fall in the same cycle with direction=RIGHT -> both press pulses high in the same cycle; direction becomes 01 (key2 wins).
5. Restart: direction=00, restart high 7 cycles while key3 is pressed -> direction 11 throughout and after; key3_press still pulses.
6. Async reset: RSTn low 3 cycles mid-count with key4 held -> all outputs at reset values immediately; one key4_press at 11 cycles after RSTn rises, direction stays 11.

Source files
------------

// File: rtl/key_input_unit.sv
// Four-button front end: synchronise, debounce, press pulses and a registered
// movement direction that refuses immediate reversals.
//
// direction state | meaning
// UP    (2'b00)   | snake moving up
// DOWN  (2'b01)   | snake moving down
// LEFT  (2'b10)   | snake moving left
// RIGHT (2'b11)   | snake moving right (reset / restart value)
module key_input_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       CLK_50M,
    input  logic       RSTn,
    input  logic       key1_n,
    input  logic       key2_n,
    input  logic       key3_n,
    input  logic       key4_n,
    input  logic       restart,
    output logic       key1_press,
    output logic       key2_press,
    output logic       key3_press,
    output logic       key4_press,
    output logic [3:0] key_level,
    output logic [1:0] direction
);

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       raw_n;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       pressed;
    logic [3:0]       level_d;
    logic [3:0]       press;
    logic [CNT_W-1:0] cnt [4];
    dir_t             dir_q;
    dir_t             dir_next;

    assign raw_n = {key4_n, key3_n, key2_n, key1_n};

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;

    // A level is only accepted after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= '0;
            end
            key_level <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (pressed[k] == key_level[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_LAST) begin
                    cnt[k]       <= '0;
                    key_level[k] <= pressed[k];
                end else begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            level_d <= '0;
            press   <= '0;
        end else begin
            level_d <= key_level;
            press   <= key_level & ~level_d;
        end
    end

    assign key1_press = press[0];
    assign key2_press = press[1];
    assign key3_press = press[2];
    assign key4_press = press[3];

    // Only the highest-priority request is examined; a rejected winner blocks the rest.
    always_comb begin
        dir_next = dir_q;
        if (restart) begin
            dir_next = RIGHT;
        end else if (press[0]) begin
            if (dir_q != DOWN) dir_next = UP;
        end else if (press[1]) begin
            if (dir_q != UP) dir_next = DOWN;
        end else if (press[2]) begin
            if (dir_q != RIGHT) dir_next = LEFT;
        end else if (press[3]) begin
            if (dir_q != LEFT) dir_next = RIGHT;
        end
    end

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            dir_q <= RIGHT;
        end else begin
            dir_q <= dir_next;
        end
    end

    assign direction = dir_q;

endmodule

// File: tb/tb_key_input_unit.sv
// Bench for key_input_unit with DEBOUNCE_CYCLES=8: directed scenarios plus
// random key activity, compared every cycle against a window-based model.
module tb_key_input_unit;

    localparam int D = 8;

    logic       CLK_50M = 1'b0;
    logic       RSTn    = 1'b0;
    logic       key1_n  = 1'b1;
    logic       key2_n  = 1'b1;
    logic       key3_n  = 1'b1;
    logic       key4_n  = 1'b1;
    logic       restart = 1'b0;
    logic       key1_press, key2_press, key3_press, key4_press;
    logic [3:0] key_level;
    logic [1:0] direction;

    int errors = 0;
    int checks = 0;
    int pulses [4];

    logic [3:0]   m_level, m_press, m_rise, m_s1, m_s2;
    logic [1:0]   m_dir;
    logic [D-1:0] m_win [4];

    key_input_unit #(.DEBOUNCE_CYCLES(D), .CNT_W(24)) dut (
        .CLK_50M(CLK_50M), .RSTn(RSTn),
        .key1_n(key1_n), .key2_n(key2_n), .key3_n(key3_n), .key4_n(key4_n),
        .restart(restart),
        .key1_press(key1_press), .key2_press(key2_press),
        .key3_press(key3_press), .key4_press(key4_press),
        .key_level(key_level), .direction(direction)
    );

    always #10 CLK_50M = ~CLK_50M;

    task automatic model_reset();
        m_level = '0;
        m_press = '0;
        m_rise  = '0;
        m_dir   = 2'b11;
        m_s1    = 4'hF;
        m_s2    = 4'hF;
        for (int k = 0; k < 4; k++) m_win[k] = '0;
    endtask

    // Reference: a key flips once the last D synchronised samples all disagree
    // with its accepted level; a pulse follows one cycle after a 0->1 flip.
    task automatic model_edge();
        logic [3:0] s;
        if (restart) begin
            m_dir = 2'b11;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_press[k]) begin
                    if (2'(k) != (m_dir ^ 2'b01)) m_dir = 2'(k);
                    break;
                end
            end
        end
        m_press = m_rise;
        s    = ~m_s2;
        m_s2 = m_s1;
        m_s1 = {key4_n, key3_n, key2_n, key1_n};
        m_rise = '0;
        for (int k = 0; k < 4; k++) begin
            m_win[k] = {m_win[k][D-2:0], s[k] != m_level[k]};
            if (&m_win[k]) begin
                m_level[k] = s[k];
                m_win[k]   = '0;
                m_rise[k]  = s[k];
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] p;
        p = {key4_press, key3_press, key2_press, key1_press};
        checks++;
        assert (key_level === m_level) else begin
            errors++;
            $error("FAIL %s key_level observed=%b expected=%b", tag, key_level, m_level);
        end
        checks++;
        assert (p === m_press) else begin
            errors++;
            $error("FAIL %s press observed=%b expected=%b", tag, p, m_press);
        end
        checks++;
        assert (direction === m_dir) else begin
            errors++;
            $error("FAIL %s direction observed=%b expected=%b", tag, direction, m_dir);
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Starts and ends on a negedge; inputs applied here are sampled at the next posedge.
    task automatic hold(input logic [3:0] keys_n, input int n, input logic rs);
        for (int i = 0; i < n; i++) begin
            {key4_n, key3_n, key2_n, key1_n} = keys_n;
            restart = rs;
            @(posedge CLK_50M);
            model_edge();
            #1;
            check_all("cycle");
            if (key1_press) pulses[0]++;
            if (key2_press) pulses[1]++;
            if (key3_press) pulses[2]++;
            if (key4_press) pulses[3]++;
            @(negedge CLK_50M);
        end
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        check_val("reset_dir", int'(direction), 3);
        check_val("reset_level", int'(key_level), 0);
        repeat (3) @(negedge CLK_50M);
        RSTn = 1'b1;
        for (int k = 0; k < 4; k++) pulses[k] = 0;
    endtask

    initial begin
        model_reset();
        for (int k = 0; k < 4; k++) pulses[k] = 0;
        @(negedge CLK_50M);

        // clean press of key1
        do_reset();
        hold(4'hF, 10, 1'b0);
        hold(4'hE, 15, 1'b0);
        hold(4'hF, 15, 1'b0);
        check_val("clean_dir", int'(direction), 0);
        check_val("clean_pulses", pulses[0], 1);

        // bouncing key3, LEFT rejected against RIGHT
        do_reset();
        for (int i = 0; i < 10; i++) hold((i % 2) ? 4'hF : 4'hB, 3, 1'b0);
        check_val("bounce_none", pulses[2], 0);
        hold(4'hB, 20, 1'b0);
        hold(4'hF, 15, 1'b0);
        check_val("bounce_pulses", pulses[2], 1);
        check_val("bounce_dir", int'(direction), 3);

        // reversal chain
        do_reset();
        hold(4'hE, 15, 1'b0); hold(4'hF, 15, 1'b0);
        check_val("chain_up", int'(direction), 0);
        hold(4'hD, 15, 1'b0); hold(4'hF, 15, 1'b0);
        check_val("chain_down_rej", int'(direction), 0);
        hold(4'hB, 15, 1'b0); hold(4'hF, 15, 1'b0);
        check_val("chain_left", int'(direction), 2);

        // simultaneous key2 + key3
        do_reset();
        hold(4'h9, 15, 1'b0);
        hold(4'hF, 15, 1'b0);
        check_val("simul_dir", int'(direction), 1);
        check_val("simul_k2", pulses[1], 1);
        check_val("simul_k3", pulses[2], 1);

        // restart overrides a key3 press
        do_reset();
        hold(4'hE, 15, 1'b0); hold(4'hF, 15, 1'b0);
        hold(4'hB, 7, 1'b0);
        hold(4'hB, 7, 1'b1);
        hold(4'hB, 6, 1'b0);
        hold(4'hF, 15, 1'b0);
        check_val("restart_dir", int'(direction), 3);
        check_val("restart_k3", pulses[2], 1);

        // reset mid-debounce with key4 held
        do_reset();
        hold(4'h7, 5, 1'b0);
        do_reset();
        hold(4'h7, 15, 1'b0);
        check_val("rst_k4", pulses[3], 1);
        check_val("rst_dir", int'(direction), 3);
        hold(4'hF, 15, 1'b0);

        // random key activity
        do_reset();
        for (int i = 0; i < 80; i++) begin
            hold(4'($urandom_range(0, 15)), $urandom_range(1, 14),
                 ($urandom_range(0, 7) == 0));
            if (i == 40) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
